memory_2p_init: RTL and testbench
=================================

Name: memory_2p_init

Overview:
- Parametrised two-port synchronous DFF memory: one write port and one registered read port, with independent addresses.
- After reset, a built-in FSM sweeps every word to INIT_VALUE; the memory then accepts traffic.
- Read-during-write collision behaviour is selectable by parameter.
- Drop-in successor to the fixed 32x4 memory in the notes/lab datapaths; defaults reproduce that geometry.

Parameters:
- WIDTH, 4, data word width in bits (>=1).
- DEPTH, 32, number of words (>=2; need not be a power of two).
- ADDR_W, $clog2(DEPTH), address width; derived, never overridden.
- INIT_VALUE, '0, WIDTH-bit value written to every word by the clear sweep.
- RDW_MODE, 0, same-address read/write collision: 0 = write-first (new data), 1 = read-first (old data).

Ports:
- clk  input  1  clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- wr_en  input  1  write strobe.
- wr_addr  input  ADDR_W  write address.
- wr_data  input  WIDTH  write data.
- rd_en  input  1  read strobe.
- rd_addr  input  ADDR_W  read address.
- rd_data  output  WIDTH  registered read data.
- rd_valid  output  1  high for exactly one cycle when rd_data carries a fresh read result.
- busy  output  1  clear sweep in progress; all requests are ignored while high.

Behaviour:
- Reset (sampled at posedge while reset=1):
  - rd_data=0, rd_valid=0, busy=1.
  - FSM goes to CLEAR and clr_addr=0.
  - Array contents are not touched in the reset cycle itself.
- FSM states: CLEAR, READY.
  - CLEAR, each cycle: mem[clr_addr]<=INIT_VALUE, then clr_addr++.
  - When clr_addr==DEPTH-1, that word is written and the next state is READY.
  - busy is high for exactly DEPTH cycles after reset deasserts, then low from the first READY cycle.
  - READY has no exit except reset.
- Reset asserted mid-sweep or in READY restarts the sweep from address 0. Partially cleared contents are irrelevant because the full sweep always completes.
- While busy=1:
  - wr_en and rd_en are ignored.
  - rd_valid stays 0 and rd_data holds its value.
- READY write: wr_en=1 and wr_addr<DEPTH -> mem[wr_addr]<=wr_data at the posedge.
- READY read:
  - rd_en=1 at edge N -> rd_data=mem[rd_addr] and rd_valid=1 after edge N (1-cycle latency).
  - rd_en=0 -> rd_valid=0 and rd_data holds its last value.
- Back-to-back reads are legal every cycle: full throughput, rd_valid stays high continuously.
- Collision (wr_en && rd_en && wr_addr==rd_addr, address in range):
  - RDW_MODE=0: rd_data=wr_data.
  - RDW_MODE=1: rd_data=old contents.
  - The write always completes.
- Out-of-range address (>=DEPTH, only possible when DEPTH is not a power of two):
  - Write is dropped.
  - Read returns 0 with rd_valid=1.
- No X may reach rd_data under any legal stimulus; the array is fully defined after the sweep.

Optional Feature:
- Macro MEMORY_2P_PARITY_EN.
- Defined:
  - Each word stores WIDTH+1 bits, the extra bit being even parity of the data.
  - Added input wr_par_flip (1 bit): when high with a write, the stored parity bit is inverted (fault injection).
  - The clear sweep writes correct parity.
  - Added output rd_parity_err (1 bit), registered alongside rd_data: high with rd_valid when the stored parity mismatches the read data; 0 otherwise; reset 0.
  - Read-first and write-first collisions both check parity on the word actually returned.
  - Out-of-range reads report no error.
- Undefined: both ports are absent and storage is WIDTH bits per word; behaviour is otherwise identical.

Decomposition:
- Package memory_pkg holds:
  - typedef enum logic {CLEAR, READY} mem_state_t.
  - Constants RDW_WRITE_FIRST=0 and RDW_READ_FIRST=1.
  - Function even_parity().
- One sub-module, memory_clear_fsm (parameters DEPTH and ADDR_W):
  - Owns the state register and clr_addr.
  - Outputs busy, clr_we and clr_addr.
- The top level muxes clr_we/clr_addr/INIT_VALUE against the user write port.

Test Plan:
- Reset then idle, defaults: busy high for exactly 32 cycles, then low. Read each address 0..31 -> rd_data=4'h0 with rd_valid one cycle after each rd_en.
- After the sweep: write addr 1 = 4'b0111, then read addr 1 -> rd_data=4'b0111 next cycle, rd_valid=1 for one cycle. Keep rd_en low -> rd_valid=0 and rd_data holds 4'b0111.
- Collision, addr 5 holding 4'h3, same-cycle write 4'hA and read of addr 5:
  - RDW_MODE=0 -> rd_data=4'hA.
  - RDW_MODE=1 -> rd_data=4'h3.
  - Either mode: a subsequent read -> 4'hA.
- Write 4'hF to addr 7, assert reset at sweep cycle 10 of a re-run, release: busy high 32 more cycles; read addr 7 -> 4'h0. A write issued while busy leaves its address at 4'h0.
- DEPTH=20, INIT_VALUE=4'h5, WIDTH=4:
  - busy lasts 20 cycles.
  - Read of addr 19 -> 4'h5.
  - Write to addr 25 is dropped and its read -> 0 with rd_valid=1.
- With MEMORY_2P_PARITY_EN:
  - Write 4'h6 with wr_par_flip=1 to addr 2, read -> rd_data=4'h6, rd_parity_err=1.
  - Rewrite with flip=0, read -> rd_parity_err=0.

Source files
------------

// File: rtl/memory_pkg.sv
// Shared types and helpers for the two-port self-clearing memory.
package memory_pkg;

  typedef enum logic {CLEAR, READY} mem_state_t;

  localparam int RDW_WRITE_FIRST = 0;
  localparam int RDW_READ_FIRST  = 1;

  // Even parity bit: makes the total number of ones (data + bit) even.
  function automatic logic even_parity(input logic [63:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/memory_clear_fsm.sv
// Post-reset sweep controller: walks clr_addr over every word once, then
// parks in READY until the next reset.
module memory_clear_fsm
  import memory_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  mem_state_t        state_reg, state_next;
  logic [ADDR_W-1:0] clr_addr_reg, clr_addr_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= CLEAR;
      clr_addr_reg <= '0;
    end else begin
      state_reg    <= state_next;
      clr_addr_reg <= clr_addr_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    clr_addr_next = clr_addr_reg;
    busy          = 1'b0;
    clr_we        = 1'b0;
    case (state_reg)
      CLEAR: begin
        busy   = 1'b1;
        clr_we = 1'b1;
        if (clr_addr_reg == LAST_ADDR) begin
          state_next    = READY;
          clr_addr_next = '0;
        end else begin
          clr_addr_next = clr_addr_reg + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign clr_addr = clr_addr_reg;

endmodule

// File: rtl/memory_2p_init.sv
// Two-port DFF memory with registered read and a post-reset clear sweep.
// Define MEMORY_2P_PARITY_EN to add a per-word parity bit with fault injection.
module memory_2p_init
  import memory_pkg::*;
#(
  parameter int               WIDTH      = 4,
  parameter int               DEPTH      = 32,
  parameter int               ADDR_W     = $clog2(DEPTH),
  parameter logic [WIDTH-1:0] INIT_VALUE = '0,
  parameter int               RDW_MODE   = RDW_WRITE_FIRST
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
`ifdef MEMORY_2P_PARITY_EN
  input  logic              wr_par_flip,
  output logic              rd_parity_err,
`endif
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid,
  output logic              busy
);

`ifdef MEMORY_2P_PARITY_EN
  localparam int SW = WIDTH + 1;
`else
  localparam int SW = WIDTH;
`endif
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  memory_clear_fsm #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clear_fsm (
    .clk      (clk),
    .reset    (reset),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  logic [SW-1:0]     mem_reg [DEPTH];
  logic              wr_in_range, rd_in_range, user_we, mem_we, collision;
  logic [ADDR_W-1:0] mem_waddr;
  logic [SW-1:0]     clr_word, user_word, mem_wword, rd_word;

  assign wr_in_range = {1'b0, wr_addr} < DEPTH_EXT;
  assign rd_in_range = {1'b0, rd_addr} < DEPTH_EXT;
  assign user_we     = !busy && wr_en && wr_in_range;
  // Nothing touches the array in a reset cycle, sweep or user write alike.
  assign mem_we      = !reset && (clr_we || user_we);
  assign mem_waddr   = clr_we ? clr_addr : wr_addr;

`ifdef MEMORY_2P_PARITY_EN
  assign clr_word  = {even_parity(64'(INIT_VALUE)), INIT_VALUE};
  assign user_word = {even_parity(64'(wr_data)) ^ wr_par_flip, wr_data};
`else
  assign clr_word  = INIT_VALUE;
  assign user_word = wr_data;
`endif
  assign mem_wword = clr_we ? clr_word : user_word;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
    always_ff @(posedge clk) begin
      if (mem_we && mem_waddr == ADDR_W'(gi)) begin
        mem_reg[gi] <= mem_wword;
      end
    end
  end

  assign collision = user_we && rd_en && (wr_addr == rd_addr);

  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      if (RDW_MODE == RDW_WRITE_FIRST && collision) begin
        rd_word = user_word;
      end else begin
        rd_word = mem_reg[rd_addr];
      end
    end
  end

  logic [WIDTH-1:0] rd_data_reg;
  logic             rd_valid_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
    end else if (!busy && rd_en) begin
      rd_data_reg  <= rd_word[WIDTH-1:0];
      rd_valid_reg <= 1'b1;
    end else begin
      rd_valid_reg <= 1'b0;
    end
  end

`ifdef MEMORY_2P_PARITY_EN
  logic rd_parity_err_reg;

  // Out-of-range reads yield an all-zero word, which is checked as clean.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_parity_err_reg <= 1'b0;
    end else if (!busy && rd_en) begin
      rd_parity_err_reg <= rd_in_range &&
                           (even_parity(64'(rd_word[WIDTH-1:0])) != rd_word[WIDTH]);
    end else begin
      rd_parity_err_reg <= 1'b0;
    end
  end

  assign rd_parity_err = rd_parity_err_reg;
`endif

  assign rd_data  = rd_data_reg;
  assign rd_valid = rd_valid_reg;

endmodule

// File: tb/tb_memory_2p_init.sv
// Scoreboard bench: three DUT instances (write-first, read-first, DEPTH=20
// with INIT_VALUE=5) share one stimulus stream; a behavioural model predicts each.
module tb_memory_2p_init;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [4:0] wr_addr = '0;
  logic [3:0] wr_data = '0;
  logic       rd_en = 1'b0;
  logic [4:0] rd_addr = '0;
  logic [3:0] rd_data_o [3];
  logic       rd_valid_o [3];
  logic       busy_o [3];
`ifdef MEMORY_2P_PARITY_EN
  logic       wr_par_flip = 1'b0;
  logic       perr_o [3];
`endif

  always #5 clk = ~clk;

  memory_2p_init #(.WIDTH(4), .DEPTH(32), .INIT_VALUE(4'h0), .RDW_MODE(0)) u_wf (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef MEMORY_2P_PARITY_EN
    .wr_par_flip(wr_par_flip), .rd_parity_err(perr_o[0]),
`endif
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_o[0]),
    .rd_valid(rd_valid_o[0]), .busy(busy_o[0]));

  memory_2p_init #(.WIDTH(4), .DEPTH(32), .INIT_VALUE(4'h0), .RDW_MODE(1)) u_rf (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef MEMORY_2P_PARITY_EN
    .wr_par_flip(wr_par_flip), .rd_parity_err(perr_o[1]),
`endif
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_o[1]),
    .rd_valid(rd_valid_o[1]), .busy(busy_o[1]));

  memory_2p_init #(.WIDTH(4), .DEPTH(20), .INIT_VALUE(4'h5), .RDW_MODE(0)) u_d20 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef MEMORY_2P_PARITY_EN
    .wr_par_flip(wr_par_flip), .rd_parity_err(perr_o[2]),
`endif
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_o[2]),
    .rd_valid(rd_valid_o[2]), .busy(busy_o[2]));

  typedef struct packed {
    logic       rst;
    logic       we;
    logic [4:0] wa;
    logic [3:0] wd;
    logic       re;
    logic [4:0] ra;
    logic       flip;
  } stim_t;

  typedef struct packed {
    logic [2:0]  v;
    logic [11:0] d;
    logic [2:0]  b;
    logic [2:0]  e;
  } exp_t;

  exp_t sb [$];
  int   checks = 0;
  int   errors = 0;

  // Behavioural model of each instance
  int         dep [3]  = '{32, 32, 20};
  logic [3:0] ini [3]  = '{4'h0, 4'h0, 4'h5};
  bit         rf  [3]  = '{1'b0, 1'b1, 1'b0};
  logic [3:0] mdl_mem  [3][32];
  logic       mdl_bad  [3][32];
  bit         mdl_busy [3];
  int         mdl_clr  [3];
  logic [3:0] mdl_hold [3];

  function automatic stim_t mk(input logic rst, we, input logic [4:0] wa,
                               input logic [3:0] wd, input logic re,
                               input logic [4:0] ra, input logic flip);
    stim_t s;
    s.rst = rst; s.we = we; s.wa = wa; s.wd = wd; s.re = re; s.ra = ra; s.flip = flip;
    return s;
  endfunction

  // Drive one cycle at the falling edge, predict outputs, advance to next falling edge.
  task automatic tick(input stim_t s);
    exp_t e;
    e = '0;
    reset = s.rst; wr_en = s.we; wr_addr = s.wa; wr_data = s.wd;
    rd_en = s.re; rd_addr = s.ra;
`ifdef MEMORY_2P_PARITY_EN
    wr_par_flip = s.flip;
`endif
    for (int k = 0; k < 3; k++) begin
      if (s.rst) begin
        mdl_busy[k] = 1'b1;
        mdl_clr[k]  = 0;
        mdl_hold[k] = 4'h0;
      end else if (mdl_busy[k]) begin
        mdl_mem[k][mdl_clr[k]] = ini[k];
        mdl_bad[k][mdl_clr[k]] = 1'b0;
        if (mdl_clr[k] == dep[k] - 1) mdl_busy[k] = 1'b0;
        mdl_clr[k]++;
      end else begin
        if (s.re) begin
          e.v[k] = 1'b1;
          if (int'(s.ra) < dep[k]) begin
            if (s.we && s.wa == s.ra && !rf[k]) begin
              mdl_hold[k] = s.wd;
              e.e[k] = s.flip;
            end else begin
              mdl_hold[k] = mdl_mem[k][s.ra];
              e.e[k] = mdl_bad[k][s.ra];
            end
          end else begin
            mdl_hold[k] = 4'h0;
          end
        end
        if (s.we && int'(s.wa) < dep[k]) begin
          mdl_mem[k][s.wa] = s.wd;
          mdl_bad[k][s.wa] = s.flip;
        end
      end
      e.d[k*4 +: 4] = mdl_hold[k];
      e.b[k] = mdl_busy[k];
    end
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    stim_t st [$];
    exp_t  e;
    st.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 32; i++) begin
      // requests early in the sweep must be ignored
      if (i < 16) st.push_back(mk(0, 1, 5'(i), 4'hE, 1, 5'(i), 0));
      else        st.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    end
    foreach (st[i]) begin
      tick(st[i]);
      e = sb.pop_front();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (rd_valid_o[k] !== e.v[k] || rd_data_o[k] !== e.d[k*4 +: 4] || busy_o[k] !== e.b[k]) begin
          errors++;
          $display("FAIL reset_sweep cyc%0d inst%0d: got v=%b d=%h busy=%b, want v=%b d=%h busy=%b",
                   i, k, rd_valid_o[k], rd_data_o[k], busy_o[k], e.v[k], e.d[k*4 +: 4], e.b[k]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t st [$];
    exp_t  e;
    for (int a = 0; a < 32; a++) st.push_back(mk(0, 0, 0, 0, 1, 5'(a), 0));
    st.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    foreach (st[i]) begin
      tick(st[i]);
      e = sb.pop_front();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (rd_valid_o[k] !== e.v[k] || rd_data_o[k] !== e.d[k*4 +: 4] || busy_o[k] !== e.b[k]) begin
          errors++;
          $display("FAIL init_read step%0d inst%0d: got v=%b d=%h busy=%b, want v=%b d=%h busy=%b",
                   i, k, rd_valid_o[k], rd_data_o[k], busy_o[k], e.v[k], e.d[k*4 +: 4], e.b[k]);
        end
      end
    end
  endtask

  task automatic test_write_read();
    stim_t st [$];
    exp_t  e;
    st.push_back(mk(0, 1, 5'd1, 4'b0111, 0, 0, 0));
    st.push_back(mk(0, 0, 0, 0, 1, 5'd1, 0));
    st.push_back(mk(0, 0, 0, 0, 0, 5'd2, 0));
    st.push_back(mk(0, 1, 5'd3, 4'h9, 0, 5'd1, 0));
    foreach (st[i]) begin
      tick(st[i]);
      e = sb.pop_front();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (rd_valid_o[k] !== e.v[k] || rd_data_o[k] !== e.d[k*4 +: 4] || busy_o[k] !== e.b[k]) begin
          errors++;
          $display("FAIL write_read step%0d inst%0d: got v=%b d=%h busy=%b, want v=%b d=%h busy=%b",
                   i, k, rd_valid_o[k], rd_data_o[k], busy_o[k], e.v[k], e.d[k*4 +: 4], e.b[k]);
        end
      end
    end
  endtask

  task automatic test_collision();
    stim_t st [$];
    exp_t  e;
    st.push_back(mk(0, 1, 5'd5, 4'h3, 0, 0, 0));
    st.push_back(mk(0, 1, 5'd5, 4'hA, 1, 5'd5, 0));
    st.push_back(mk(0, 0, 0, 0, 1, 5'd5, 0));
    st.push_back(mk(0, 1, 5'd6, 4'hC, 1, 5'd5, 0));
    foreach (st[i]) begin
      tick(st[i]);
      e = sb.pop_front();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (rd_valid_o[k] !== e.v[k] || rd_data_o[k] !== e.d[k*4 +: 4] || busy_o[k] !== e.b[k]) begin
          errors++;
          $display("FAIL collision step%0d inst%0d: got v=%b d=%h busy=%b, want v=%b d=%h busy=%b",
                   i, k, rd_valid_o[k], rd_data_o[k], busy_o[k], e.v[k], e.d[k*4 +: 4], e.b[k]);
        end
      end
    end
  endtask

  task automatic test_reset_restart();
    stim_t st [$];
    exp_t  e;
    st.push_back(mk(0, 1, 5'd7, 4'hF, 0, 0, 0));
    st.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 10; i++) st.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    st.push_back(mk(1, 1, 5'd7, 4'hF, 0, 0, 0));
    for (int i = 0; i < 32; i++) begin
      if (i == 3) st.push_back(mk(0, 1, 5'd9, 4'hC, 1, 5'd9, 0));
      else        st.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    end
    st.push_back(mk(0, 0, 0, 0, 1, 5'd7, 0));
    st.push_back(mk(0, 0, 0, 0, 1, 5'd9, 0));
    foreach (st[i]) begin
      tick(st[i]);
      e = sb.pop_front();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (rd_valid_o[k] !== e.v[k] || rd_data_o[k] !== e.d[k*4 +: 4] || busy_o[k] !== e.b[k]) begin
          errors++;
          $display("FAIL reset_restart step%0d inst%0d: got v=%b d=%h busy=%b, want v=%b d=%h busy=%b",
                   i, k, rd_valid_o[k], rd_data_o[k], busy_o[k], e.v[k], e.d[k*4 +: 4], e.b[k]);
        end
      end
    end
  endtask

  task automatic test_out_of_range();
    stim_t st [$];
    exp_t  e;
    st.push_back(mk(0, 1, 5'd25, 4'h9, 0, 0, 0));
    st.push_back(mk(0, 0, 0, 0, 1, 5'd25, 0));
    st.push_back(mk(0, 0, 0, 0, 1, 5'd19, 0));
    st.push_back(mk(0, 1, 5'd19, 4'h2, 1, 5'd31, 0));
    st.push_back(mk(0, 0, 0, 0, 1, 5'd19, 0));
    foreach (st[i]) begin
      tick(st[i]);
      e = sb.pop_front();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (rd_valid_o[k] !== e.v[k] || rd_data_o[k] !== e.d[k*4 +: 4] || busy_o[k] !== e.b[k]) begin
          errors++;
          $display("FAIL out_of_range step%0d inst%0d: got v=%b d=%h busy=%b, want v=%b d=%h busy=%b",
                   i, k, rd_valid_o[k], rd_data_o[k], busy_o[k], e.v[k], e.d[k*4 +: 4], e.b[k]);
        end
      end
    end
  endtask

`ifdef MEMORY_2P_PARITY_EN
  task automatic test_parity();
    stim_t st [$];
    exp_t  e;
    st.push_back(mk(0, 1, 5'd2, 4'h6, 0, 0, 1));
    st.push_back(mk(0, 0, 0, 0, 1, 5'd2, 0));
    st.push_back(mk(0, 1, 5'd2, 4'h6, 0, 0, 0));
    st.push_back(mk(0, 0, 0, 0, 1, 5'd2, 0));
    st.push_back(mk(0, 1, 5'd4, 4'hB, 1, 5'd4, 1));
    st.push_back(mk(0, 0, 0, 0, 1, 5'd4, 0));
    st.push_back(mk(0, 0, 0, 0, 1, 5'd30, 0));
    foreach (st[i]) begin
      tick(st[i]);
      e = sb.pop_front();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (rd_valid_o[k] !== e.v[k] || rd_data_o[k] !== e.d[k*4 +: 4] || perr_o[k] !== e.e[k]) begin
          errors++;
          $display("FAIL parity step%0d inst%0d: got v=%b d=%h err=%b, want v=%b d=%h err=%b",
                   i, k, rd_valid_o[k], rd_data_o[k], perr_o[k], e.v[k], e.d[k*4 +: 4], e.e[k]);
        end
      end
    end
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_write_read();
    test_collision();
    test_reset_restart();
    test_out_of_range();
`ifdef MEMORY_2P_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
